// File: rtl/seg_scan_rx.sv
// Multiplexed 7-segment bus receiver: sync, settle, decode, frame assembly.
// Define SEG_SCAN_RX_CHG_ONLY_EN to publish only frames that differ.
module seg_scan_rx #(
  parameter int N_DIG       = 4,
  parameter int STABLE_CYC  = 8,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [6:0]         ss,
  input  logic [N_DIG-1:0]   dig,
  output logic [4*N_DIG-1:0] frame,
  output logic               frame_vld,
  output logic [N_DIG-1:0]   blank,
  output logic               dec_err
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [6:0]       SS_OFF  = {7{SEG_ACT_LOW}};
  localparam logic [N_DIG-1:0] DIG_OFF = {N_DIG{DIG_ACT_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  function automatic logic [4:0] dec7(input logic [6:0] p);
    logic [4:0] r;
    unique case (p)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Sync flops reset to the idle bus level so no false strobes appear.
  logic [6:0]       ss_s1_q, ss_s2_q;
  logic [N_DIG-1:0] dig_s1_q, dig_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s1_q  <= SS_OFF;
      ss_s2_q  <= SS_OFF;
      dig_s1_q <= DIG_OFF;
      dig_s2_q <= DIG_OFF;
    end else begin
      ss_s1_q  <= ss;
      ss_s2_q  <= ss_s1_q;
      dig_s1_q <= dig;
      dig_s2_q <= dig_s1_q;
    end
  end

  logic [6:0]       seg_on;
  logic [N_DIG-1:0] dig_on;
  logic             one_hot, multi;

  assign seg_on  = SEG_ACT_LOW ? ~ss_s2_q : ss_s2_q;
  assign dig_on  = DIG_ACT_LOW ? ~dig_s2_q : dig_s2_q;
  assign one_hot = (dig_on != '0) &&
                   ((dig_on & (dig_on - N_DIG'(1))) == '0);
  assign multi   = (dig_on != '0) && !one_hot;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_DIG-1:0]    strb_q, strb_d;
  logic [6:0]          pat_q, pat_d;
  logic [N_DIG-1:0]    mask_q, mask_d;
  logic [4*N_DIG-1:0]  shadow_q, shadow_d;
  logic [N_DIG-1:0]    sblank_q, sblank_d;
  logic [4*N_DIG-1:0]  frame_q;
  logic [N_DIG-1:0]    blank_q;
  logic                vld_q, err_q;
  logic                chg, cap, err_set, done, upd;
  logic [4:0]          dec;
  logic                is_blank, bad;

  assign chg = (dig_on != strb_q) || (seg_on != pat_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = strb_q;
    pat_d   = pat_q;
    cap     = 1'b0;
    err_set = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (one_hot) begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
            strb_d  = dig_on;
            pat_d   = seg_on;
            if (STABLE_CYC == 1) begin
              cap     = 1'b1;
              state_d = HOLD;
            end
          end else if (multi) begin
            err_set = 1'b1;
          end
        end
        SETTLE: begin
          if (chg) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(STABLE_CYC)) begin
              cap     = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (chg) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    dec      = dec7(pat_d);
    is_blank = (pat_d == 7'h00);
    bad      = dec[4] && !is_blank;
    shadow_d = shadow_q;
    sblank_d = sblank_q;
    mask_d   = mask_q;
    if (cap) begin
      for (int k = 0; k < N_DIG; k++) begin
        if (strb_d[k]) begin
          shadow_d[4*k +: 4] = dec[3:0];
          sblank_d[k]        = is_blank;
          mask_d[k]          = 1'b1;
        end
      end
    end
    done = &mask_d;
`ifdef SEG_SCAN_RX_CHG_ONLY_EN
    upd = (shadow_d != frame_q) || (sblank_d != blank_q);
`else
    upd = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      strb_q   <= '0;
      pat_q    <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
      sblank_q <= '0;
      frame_q  <= '0;
      blank_q  <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      strb_q   <= strb_d;
      pat_q    <= pat_d;
      shadow_q <= shadow_d;
      sblank_q <= sblank_d;
      mask_q   <= done ? '0 : mask_d;
      vld_q    <= done && upd;
      if (done && upd) begin
        frame_q <= shadow_d;
        blank_q <= sblank_d;
      end
      if (err_set || (cap && bad))
        err_q <= 1'b1;
    end
  end

  assign frame     = frame_q;
  assign frame_vld = vld_q;
  assign blank     = blank_q;
  assign dec_err   = err_q;

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed bench for seg_scan_rx: scan, settle, blank/error, reset, enable.
module tb_seg_scan_rx;

`ifdef SEG_SCAN_RX_CHG_ONLY_EN
  localparam int CHG = 1;
`else
  localparam int CHG = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [6:0]  ss = 7'h7F;
  logic [3:0]  dig = 4'hF;
  logic [15:0] frame;
  logic        frame_vld;
  logic [3:0]  blank;
  logic        dec_err;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;

  seg_scan_rx #(
    .N_DIG(4), .STABLE_CYC(8), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ss(ss), .dig(dig),
    .frame(frame), .frame_vld(frame_vld), .blank(blank), .dec_err(dec_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_vld === 1'b1) vld_cnt++;

  // k=0 means no strobe and all segments off; pat is active-high gfedcba
  task automatic drive(input int k, input logic [6:0] pat, input int n);
    dig = (k == 0) ? 4'hF : ~(4'b0001 << (k - 1));
    ss  = ~pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [6:0] p4, p3, p2, p1);
    drive(4, p4, 20);
    drive(3, p3, 20);
    drive(2, p2, 20);
    drive(1, p1, 20);
    drive(0, 7'h00, 5);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (frame !== 16'h0) begin failures++;
      $display("FAIL rst_frame got=%h exp=0000", frame); end
    checks++; if (frame_vld !== 1'b0) begin failures++;
      $display("FAIL rst_vld got=%b exp=0", frame_vld); end
    checks++; if (blank !== 4'h0) begin failures++;
      $display("FAIL rst_blank got=%b exp=0000", blank); end
    checks++; if (dec_err !== 1'b0) begin failures++;
      $display("FAIL rst_err got=%b exp=0", dec_err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    drive(0, 7'h00, 4);
  endtask

  task automatic test_scan();
    int base;
    base = vld_cnt;
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    checks++; if (frame !== 16'h1234) begin failures++;
      $display("FAIL scan_frame got=%h exp=1234", frame); end
    checks++; if (vld_cnt - base !== 1) begin failures++;
      $display("FAIL scan_vld1 got=%0d exp=1", vld_cnt - base); end
    checks++; if (blank !== 4'h0) begin failures++;
      $display("FAIL scan_blank got=%b exp=0000", blank); end
    checks++; if (dec_err !== 1'b0) begin failures++;
      $display("FAIL scan_err got=%b exp=0", dec_err); end
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    checks++; if (vld_cnt - base !== 2 - CHG) begin failures++;
      $display("FAIL scan_vld2 got=%0d exp=%0d", vld_cnt - base, 2 - CHG); end
  endtask

  task automatic test_latency();
    int lat;
    lat = 0;
    drive(4, 7'h06, 20);
    drive(3, 7'h5B, 20);
    drive(2, 7'h4F, 20);
    drive(0, 7'h00, 5);
    dig = 4'b1110;
    ss  = ~7'h6D;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (frame_vld === 1'b1 && lat == 0) lat = i;
    end
    drive(0, 7'h00, 5);
    checks++; if (lat !== 10) begin failures++;
      $display("FAIL latency got=%0d exp=10 frame=%h", lat, frame); end
  endtask

  task automatic test_glitch();
    int base;
    drive(4, 7'h06, 20);
    drive(3, 7'h5B, 20);
    drive(2, 7'h4F, 20);
    drive(0, 7'h00, 3);
    base = vld_cnt;
    drive(1, 7'h66, 7);
    drive(0, 7'h00, 10);
    checks++; if (vld_cnt - base !== 0) begin failures++;
      $display("FAIL glitch_short got=%0d exp=0", vld_cnt - base); end
    drive(1, 7'h66, 8);
    drive(0, 7'h00, 10);
    checks++; if (vld_cnt - base !== 1) begin failures++;
      $display("FAIL glitch_exact got=%0d exp=1", vld_cnt - base); end
    checks++; if (frame !== 16'h1234) begin failures++;
      $display("FAIL glitch_frame got=%h exp=1234", frame); end
  endtask

  task automatic test_blank_err();
    scan(7'h06, 7'h5B, 7'h00, 7'h66);
    checks++; if (frame !== 16'h1204) begin failures++;
      $display("FAIL blank_frame got=%h exp=1204", frame); end
    checks++; if (blank !== 4'b0010) begin failures++;
      $display("FAIL blank_bits got=%b exp=0010", blank); end
    checks++; if (dec_err !== 1'b0) begin failures++;
      $display("FAIL blank_err got=%b exp=0", dec_err); end
    scan(7'h06, 7'h5B, 7'h4F, 7'h01);
    checks++; if (dec_err !== 1'b1) begin failures++;
      $display("FAIL bad_err got=%b exp=1", dec_err); end
    checks++; if (frame !== 16'h1230) begin failures++;
      $display("FAIL bad_frame got=%h exp=1230", frame); end
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    checks++; if (dec_err !== 1'b1) begin failures++;
      $display("FAIL err_sticky got=%b exp=1", dec_err); end
    checks++; if (blank !== 4'b0000) begin failures++;
      $display("FAIL blank_clr got=%b exp=0000", blank); end
  endtask

  task automatic test_reset_mid();
    int base;
    drive(4, 7'h06, 20);
    drive(3, 7'h5B, 20);
    drive(2, 7'h4F, 20);
    drive(1, 7'h66, 5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (frame !== 16'h0) begin failures++;
      $display("FAIL mid_frame got=%h exp=0000", frame); end
    checks++; if (dec_err !== 1'b0) begin failures++;
      $display("FAIL mid_err got=%b exp=0", dec_err); end
    checks++; if (blank !== 4'h0) begin failures++;
      $display("FAIL mid_blank got=%b exp=0000", blank); end
    checks++; if (frame_vld !== 1'b0) begin failures++;
      $display("FAIL mid_vld got=%b exp=0", frame_vld); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = vld_cnt;
    repeat (30) @(negedge clk);
    drive(0, 7'h00, 5);
    checks++; if (vld_cnt - base !== 0) begin failures++;
      $display("FAIL mid_novld got=%0d exp=0", vld_cnt - base); end
    checks++; if (frame !== 16'h0) begin failures++;
      $display("FAIL mid_hold got=%h exp=0000", frame); end
  endtask

  task automatic test_two_strobes();
    int base;
    do_reset();
    base = vld_cnt;
    dig = 4'b1100;
    ss  = ~7'h06;
    repeat (20) @(negedge clk);
    checks++; if (dec_err !== 1'b1) begin failures++;
      $display("FAIL two_err got=%b exp=1", dec_err); end
    drive(4, 7'h06, 20);
    drive(3, 7'h5B, 20);
    drive(2, 7'h4F, 20);
    drive(0, 7'h00, 10);
    checks++; if (vld_cnt - base !== 0) begin failures++;
      $display("FAIL two_nocap got=%0d exp=0", vld_cnt - base); end
  endtask

  task automatic test_en_off();
    int base;
    base = vld_cnt;
    en = 1'b0;
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    checks++; if (vld_cnt - base !== 0) begin failures++;
      $display("FAIL en_off got=%0d exp=0", vld_cnt - base); end
    en = 1'b1;
    drive(0, 7'h00, 5);
  endtask

  task automatic test_chg_only();
    int base;
    base = vld_cnt;
    repeat (3) scan(7'h77, 7'h7C, 7'h39, 7'h5E);
    checks++; if (vld_cnt - base !== (CHG ? 1 : 3)) begin failures++;
      $display("FAIL chg_vld got=%0d exp=%0d", vld_cnt - base, CHG ? 1 : 3); end
    checks++; if (frame !== 16'hABCD) begin failures++;
      $display("FAIL chg_frame got=%h exp=abcd", frame); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_scan();
    test_latency();
    test_glitch();
    test_blank_err();
    test_reset_mid();
    test_two_strobes();
    test_en_off();
    test_chg_only();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
